// File: rtl/bus_pkg.sv
// bus_pkg: bus operation encodings and agent FSM states shared by bus and cache controllers
package bus_pkg;
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_RDX  = 2'b10,
    OP_UPGR = 2'b11
  } bus_op_t;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } agent_state_t;
endpackage

// File: rtl/snoop_responder.sv
// snoop_responder: gates snoops of the other core's broadcasts and registers the L1 hit/flush response
module snoop_responder
  import bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grant,
  input  logic [1:0]        bus_operation_in,
  input  logic [ADDR_W-1:0] bus_address_in,
  input  logic              snoop_hit,
  input  logic              snoop_dirty,
  input  logic [DATA_W-1:0] snoop_data,
  output logic              snoop_valid,
  output logic [1:0]        snoop_op,
  output logic [ADDR_W-1:0] snoop_addr,
  output logic              cache_hit_out,
  output logic              flush_out,
  output logic [DATA_W-1:0] bus_data_out
);
  logic hit_d, flush_d;
  logic hit_q, flush_q;
  logic [DATA_W-1:0] data_d, data_q;
  // A broadcast is snooped only when it is not our own granted transaction
  always_comb begin
    snoop_valid = reset && !grant && bus_operation_in != OP_NONE;
    snoop_op    = snoop_valid ? bus_operation_in : OP_NONE;
    snoop_addr  = snoop_valid ? bus_address_in : '0;
    hit_d       = snoop_valid && snoop_hit;
    flush_d     = hit_d && snoop_dirty;
    data_d      = flush_d ? snoop_data : '0;
  end
  // The response lives for exactly one cycle after each snoop lookup
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q   <= 1'b0;
      flush_q <= 1'b0;
      data_q  <= '0;
    end else begin
      hit_q   <= hit_d;
      flush_q <= flush_d;
      data_q  <= data_d;
    end
  end
  assign cache_hit_out = hit_q;
  assign flush_out     = flush_q;
  assign bus_data_out  = data_q;
endmodule

// File: rtl/core_bus_agent.sv
// core_bus_agent: turns L1 miss/upgrade requests into arbitrated bus operations and answers remote snoops
module core_bus_agent
  import bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RESP_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cache_req_valid,
  input  logic [1:0]        cache_req_op,
  input  logic [ADDR_W-1:0] cache_req_addr,
  output logic              cache_req_ready,
  output logic              cache_resp_valid,
  output logic [DATA_W-1:0] cache_resp_data,
  output logic              cache_resp_shared,
  output logic              req_core,
  input  logic              grant,
  output logic [1:0]        bus_operation_out,
  output logic [ADDR_W-1:0] bus_address_out,
  output logic [DATA_W-1:0] bus_data_out,
  output logic              flush_out,
  output logic              cache_hit_out,
  input  logic [1:0]        bus_operation_in,
  input  logic [ADDR_W-1:0] bus_address_in,
  input  logic [DATA_W-1:0] bus_data_in,
  input  logic              cache_hit_in,
  output logic              snoop_valid,
  output logic [1:0]        snoop_op,
  output logic [ADDR_W-1:0] snoop_addr,
  input  logic              snoop_hit,
  input  logic              snoop_dirty,
  input  logic [DATA_W-1:0] snoop_data
);
  localparam logic [3:0] LAT_M1 = 4'(RESP_LAT - 1);
  agent_state_t state_d, state_q;
  bus_op_t req_op, op_q, bus_op_q;
  logic [ADDR_W-1:0] addr_q, bus_addr_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [3:0] cnt_q;
  logic ready_q, req_q, resp_valid_q, resp_shared_q;
  assign req_op = bus_op_t'(cache_req_op);
  // Next state; losing grant mid-operation falls back to REQ so the latched op retries
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = cache_req_valid && req_op != OP_NONE ? ST_REQ : ST_IDLE;
      ST_REQ:   state_d = grant ? ST_ISSUE : ST_REQ;
      ST_ISSUE: state_d = !grant ? ST_REQ : (op_q == OP_UPGR ? ST_DONE : ST_WAIT);
      ST_WAIT:  state_d = !grant ? ST_REQ : (cnt_q == LAT_M1 ? ST_DONE : ST_WAIT);
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end
  // State, request latch, latency counter and outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_NONE;
      addr_q        <= '0;
      cnt_q         <= '0;
      ready_q       <= 1'b0;
      req_q         <= 1'b0;
      bus_op_q      <= OP_NONE;
      bus_addr_q    <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_shared_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= state_d == ST_IDLE;
      req_q        <= state_d inside {ST_REQ, ST_ISSUE, ST_WAIT};
      bus_op_q     <= state_d == ST_ISSUE ? op_q : OP_NONE;
      bus_addr_q   <= state_d == ST_ISSUE ? addr_q : '0;
      resp_valid_q <= state_d == ST_DONE;
      cnt_q        <= state_q == ST_WAIT && grant ? cnt_q + 4'd1 : 4'd0;
      if (state_q == ST_IDLE && state_d == ST_REQ) begin
        op_q   <= req_op;
        addr_q <= cache_req_addr;
      end
      if (state_q == ST_WAIT && state_d == ST_DONE) begin
        resp_data_q   <= bus_data_in;
        resp_shared_q <= cache_hit_in;
      end
      if (state_q == ST_ISSUE && state_d == ST_DONE) begin
        resp_data_q   <= '0;
        resp_shared_q <= cache_hit_in;
      end
    end
  end
  assign cache_req_ready   = ready_q;
  assign req_core          = req_q;
  assign bus_operation_out = bus_op_q;
  assign bus_address_out   = bus_addr_q;
  assign cache_resp_valid  = resp_valid_q;
  assign cache_resp_data   = resp_data_q;
  assign cache_resp_shared = resp_shared_q;
  snoop_responder #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_snoop (
    .clk              (clk),
    .reset            (reset),
    .grant            (grant),
    .bus_operation_in (bus_operation_in),
    .bus_address_in   (bus_address_in),
    .snoop_hit        (snoop_hit),
    .snoop_dirty      (snoop_dirty),
    .snoop_data       (snoop_data),
    .snoop_valid      (snoop_valid),
    .snoop_op         (snoop_op),
    .snoop_addr       (snoop_addr),
    .cache_hit_out    (cache_hit_out),
    .flush_out        (flush_out),
    .bus_data_out     (bus_data_out)
  );
endmodule

// File: tb/tb_core_bus_agent.sv
// tb_core_bus_agent: directed vectors with hand-computed expectations for core_bus_agent
module tb_core_bus_agent;
  logic        clk, reset;
  logic        cache_req_valid;
  logic [1:0]  cache_req_op;
  logic [31:0] cache_req_addr;
  logic        cache_req_ready, cache_resp_valid, cache_resp_shared;
  logic [31:0] cache_resp_data;
  logic        req_core, grant;
  logic [1:0]  bus_operation_out, bus_operation_in, snoop_op;
  logic [31:0] bus_address_out, bus_data_out, bus_address_in, bus_data_in;
  logic        flush_out, cache_hit_out, cache_hit_in;
  logic        snoop_valid, snoop_hit, snoop_dirty;
  logic [31:0] snoop_addr, snoop_data;
  int checks = 0, errors = 0;
  int n_req = 0, n_issue = 0, n_resp = 0;
  core_bus_agent #(.ADDR_W(32), .DATA_W(32), .RESP_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .cache_req_valid(cache_req_valid), .cache_req_op(cache_req_op), .cache_req_addr(cache_req_addr),
    .cache_req_ready(cache_req_ready), .cache_resp_valid(cache_resp_valid),
    .cache_resp_data(cache_resp_data), .cache_resp_shared(cache_resp_shared),
    .req_core(req_core), .grant(grant),
    .bus_operation_out(bus_operation_out), .bus_address_out(bus_address_out),
    .bus_data_out(bus_data_out), .flush_out(flush_out), .cache_hit_out(cache_hit_out),
    .bus_operation_in(bus_operation_in), .bus_address_in(bus_address_in),
    .bus_data_in(bus_data_in), .cache_hit_in(cache_hit_in),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty), .snoop_data(snoop_data)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
    n_req   += int'(req_core);
    n_issue += int'(bus_operation_out != 2'b00);
    n_resp  += int'(cache_resp_valid);
  endtask
  task automatic clr();
    n_req = 0;
    n_issue = 0;
    n_resp = 0;
  endtask
  task automatic req(input logic [1:0] op, input logic [31:0] addr);
    cache_req_valid = 1'b1;
    cache_req_op = op;
    cache_req_addr = addr;
  endtask
  initial begin
    reset = 1'b0; grant = 1'b0;
    cache_req_valid = 1'b0; cache_req_op = 2'b00; cache_req_addr = '0;
    bus_operation_in = 2'b00; bus_address_in = '0; bus_data_in = '0; cache_hit_in = 1'b0;
    snoop_hit = 1'b0; snoop_dirty = 1'b0; snoop_data = '0;
    tick(); tick();
    chk("rst_ready", {31'd0, cache_req_ready}, 32'd0);
    chk("rst_req", {31'd0, req_core}, 32'd0);
    chk("rst_resp", {31'd0, cache_resp_valid}, 32'd0);
    chk("rst_snoop", {31'd0, snoop_valid}, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_ready", {31'd0, cache_req_ready}, 32'd1);
    cache_req_valid = 1'b1; cache_req_op = 2'b00;
    tick();
    chk("none_ignored", {31'd0, req_core}, 32'd0);
    clr();
    req(2'b01, 32'h40); bus_data_in = 32'hDEADBEEF; cache_hit_in = 1'b0;
    tick(); cache_req_valid = 1'b0;
    chk("rd_req", {31'd0, req_core}, 32'd1);
    chk("rd_busy", {31'd0, cache_req_ready}, 32'd0);
    tick();
    tick(); grant = 1'b1;
    tick();
    chk("rd_issue_op", {30'd0, bus_operation_out}, 32'd1);
    chk("rd_issue_addr", bus_address_out, 32'h40);
    tick();
    chk("rd_wait_op", {30'd0, bus_operation_out}, 32'd0);
    tick();
    tick(); grant = 1'b0;
    chk("rd_done", {31'd0, cache_resp_valid}, 32'd1);
    chk("rd_data", cache_resp_data, 32'hDEADBEEF);
    chk("rd_shared", {31'd0, cache_resp_shared}, 32'd0);
    chk("rd_done_req", {31'd0, req_core}, 32'd0);
    tick();
    chk("rd_pulse", {31'd0, cache_resp_valid}, 32'd0);
    chk("rd_hold", cache_resp_data, 32'hDEADBEEF);
    chk("rd_req_cycles", n_req, 6);
    chk("rd_issue_cycles", n_issue, 1);
    clr();
    req(2'b11, 32'h80); grant = 1'b1; cache_hit_in = 1'b1;
    tick(); cache_req_valid = 1'b0;
    tick();
    chk("up_issue_op", {30'd0, bus_operation_out}, 32'd3);
    chk("up_issue_addr", bus_address_out, 32'h80);
    tick(); grant = 1'b0; cache_hit_in = 1'b0;
    chk("up_done", {31'd0, cache_resp_valid}, 32'd1);
    chk("up_data", cache_resp_data, 32'd0);
    chk("up_shared", {31'd0, cache_resp_shared}, 32'd1);
    tick();
    chk("up_req_cycles", n_req, 2);
    chk("up_hold_shared", {31'd0, cache_resp_shared}, 32'd1);
    bus_operation_in = 2'b10; bus_address_in = 32'h100;
    snoop_hit = 1'b1; snoop_dirty = 1'b1; snoop_data = 32'h12345678;
    #1;
    chk("sn_valid", {31'd0, snoop_valid}, 32'd1);
    chk("sn_op", {30'd0, snoop_op}, 32'd2);
    chk("sn_addr", snoop_addr, 32'h100);
    tick();
    bus_operation_in = 2'b00; snoop_hit = 1'b0; snoop_dirty = 1'b0; snoop_data = '0;
    chk("sn_hit", {31'd0, cache_hit_out}, 32'd1);
    chk("sn_flush", {31'd0, flush_out}, 32'd1);
    chk("sn_data", bus_data_out, 32'h12345678);
    tick();
    chk("sn_hit_clr", {31'd0, cache_hit_out}, 32'd0);
    chk("sn_flush_clr", {31'd0, flush_out}, 32'd0);
    chk("sn_data_clr", bus_data_out, 32'd0);
    bus_operation_in = 2'b01; snoop_hit = 1'b1; snoop_data = 32'hAAAA5555;
    tick();
    bus_operation_in = 2'b10; snoop_dirty = 1'b1; snoop_data = 32'h0F0F0F0F;
    chk("b2b_hit1", {31'd0, cache_hit_out}, 32'd1);
    chk("b2b_flush1", {31'd0, flush_out}, 32'd0);
    chk("b2b_data1", bus_data_out, 32'd0);
    tick();
    bus_operation_in = 2'b01; grant = 1'b1;
    chk("b2b_flush2", {31'd0, flush_out}, 32'd1);
    chk("b2b_data2", bus_data_out, 32'h0F0F0F0F);
    #1;
    chk("self_nosnoop", {31'd0, snoop_valid}, 32'd0);
    tick();
    bus_operation_in = 2'b00; grant = 1'b0; snoop_hit = 1'b0; snoop_dirty = 1'b0;
    chk("self_nohit", {31'd0, cache_hit_out}, 32'd0);
    clr();
    req(2'b01, 32'hC0); grant = 1'b1; bus_data_in = 32'hCAFEF00D;
    tick(); cache_req_valid = 1'b0;
    tick();
    tick(); grant = 1'b0;
    tick();
    chk("gl_req", {31'd0, req_core}, 32'd1);
    chk("gl_nobus", {30'd0, bus_operation_out}, 32'd0);
    chk("gl_noresp", {31'd0, cache_resp_valid}, 32'd0);
    grant = 1'b1;
    tick();
    chk("gl_reissue_op", {30'd0, bus_operation_out}, 32'd1);
    chk("gl_reissue_addr", bus_address_out, 32'hC0);
    tick();
    tick();
    tick(); grant = 1'b0;
    chk("gl_done", {31'd0, cache_resp_valid}, 32'd1);
    chk("gl_data", cache_resp_data, 32'hCAFEF00D);
    tick();
    chk("gl_resp_count", n_resp, 1);
    chk("gl_issue_count", n_issue, 2);
    req(2'b01, 32'h200); bus_data_in = 32'h0BADF00D; cache_hit_in = 1'b1;
    tick(); cache_req_valid = 1'b0;
    bus_operation_in = 2'b01; bus_address_in = 32'h300; snoop_hit = 1'b0; snoop_dirty = 1'b1; snoop_data = 32'h55;
    #1;
    chk("rq_snoop_valid", {31'd0, snoop_valid}, 32'd1);
    tick();
    bus_operation_in = 2'b00; snoop_dirty = 1'b0;
    chk("rq_snoop_hit", {31'd0, cache_hit_out}, 32'd0);
    chk("rq_snoop_flush", {31'd0, flush_out}, 32'd0);
    chk("rq_still_req", {31'd0, req_core}, 32'd1);
    grant = 1'b1;
    tick();
    tick();
    tick();
    tick(); grant = 1'b0;
    chk("rq_done", {31'd0, cache_resp_valid}, 32'd1);
    chk("rq_data", cache_resp_data, 32'h0BADF00D);
    chk("rq_shared", {31'd0, cache_resp_shared}, 32'd1);
    tick();
    req(2'b10, 32'h400); grant = 1'b1;
    tick(); cache_req_valid = 1'b0;
    tick();
    tick();
    chk("rs_in_wait", {31'd0, req_core}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rs_req", {31'd0, req_core}, 32'd0);
    chk("rs_ready", {31'd0, cache_req_ready}, 32'd0);
    chk("rs_data", cache_resp_data, 32'd0);
    chk("rs_shared", {31'd0, cache_resp_shared}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("rs_idle_ready", {31'd0, cache_req_ready}, 32'd1);
    chk("rs_discarded", {31'd0, req_core}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
